// File: rtl/pw_pkg.sv
// Shared state encoding and active-low 7-segment glyphs
// for the password lockout controller.
package pw_pkg;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    OPEN     = 2'd1,
    LOCKED   = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, low = lit
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_GUION = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_D0    = 7'b1000000;
  localparam logic [6:0] SEG_D1    = 7'b1111001;
  localparam logic [6:0] SEG_D2    = 7'b0100100;
  localparam logic [6:0] SEG_D3    = 7'b0110000;
  localparam logic [6:0] SEG_D4    = 7'b0011001;
  localparam logic [6:0] SEG_D5    = 7'b0010010;
  localparam logic [6:0] SEG_D6    = 7'b0000010;
  localparam logic [6:0] SEG_D7    = 7'b1111000;
  localparam logic [6:0] SEG_D8    = 7'b0000000;
  localparam logic [6:0] SEG_D9    = 7'b0010000;

endpackage

// File: rtl/seg7_digit.sv
// 4-bit value to active-low 7-segment code;
// values above 9 are blanked.
module seg7_digit
  import pw_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_val)
      4'd0:    o_seg = SEG_D0;
      4'd1:    o_seg = SEG_D1;
      4'd2:    o_seg = SEG_D2;
      4'd3:    o_seg = SEG_D3;
      4'd4:    o_seg = SEG_D4;
      4'd5:    o_seg = SEG_D5;
      4'd6:    o_seg = SEG_D6;
      4'd7:    o_seg = SEG_D7;
      4'd8:    o_seg = SEG_D8;
      4'd9:    o_seg = SEG_D9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/password_lockout_ctrl.sv
// Lockout/unlock sequencer around the password checker:
// counts failed tries, times the lockout and open windows.
module password_lockout_ctrl
  import pw_pkg::*;
#(
  parameter int MAX_TRIES  = 3,
  parameter int LOCK_TICKS = 9,
  parameter int OPEN_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       done_pulse,
  input  logic       error_pulse,
  input  logic       sw_any,
  output logic       checker_en,
  output logic       checker_clr,
  output logic       unlocked,
  output logic       locked,
  output logic [1:0] tries_left,
  output logic [6:0] HEX4
);

  localparam logic [1:0] MAX_T   = 2'(MAX_TRIES);
  localparam logic [3:0] LOCK_LD = 4'(LOCK_TICKS);
  localparam logic [3:0] OPEN_LD = 4'(OPEN_TICKS);

  state_t     r_state;
  logic [1:0] r_fail_cnt;
  logic [3:0] r_lock_cnt;
  logic [3:0] r_open_cnt;

  state_t     w_state_nxt;
  logic [1:0] w_fail_nxt;
  logic [3:0] w_lock_nxt;
  logic [3:0] w_open_nxt;
  logic [3:0] w_seg_val;
  logic [6:0] w_seg;

  // Loads happen on the ARMED exit edge, so a tick there never
  // reaches the freshly loaded timer.
  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail_cnt;
    w_lock_nxt  = r_lock_cnt;
    w_open_nxt  = r_open_cnt;
    unique case (r_state)
      ARMED: begin
        if (error_pulse) begin
          if (r_fail_cnt + 2'd1 == MAX_T) begin
            w_state_nxt = LOCKED;
            w_fail_nxt  = 2'd0;
            w_lock_nxt  = LOCK_LD;
          end else begin
            w_fail_nxt = r_fail_cnt + 2'd1;
          end
        end else if (done_pulse) begin
          w_state_nxt = OPEN;
          w_fail_nxt  = 2'd0;
          w_open_nxt  = OPEN_LD;
        end
      end
      OPEN: begin
        if (tick && r_open_cnt != 4'd0) begin
          w_open_nxt = r_open_cnt - 4'd1;
          if (r_open_cnt == 4'd1)
            w_state_nxt = WAIT_CLR;
        end
      end
      LOCKED: begin
        if (tick && r_lock_cnt != 4'd0) begin
          w_lock_nxt = r_lock_cnt - 4'd1;
          if (r_lock_cnt == 4'd1)
            w_state_nxt = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (!sw_any)
          w_state_nxt = ARMED;
      end
      default: w_state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARMED;
      r_fail_cnt <= 2'd0;
      r_lock_cnt <= 4'd0;
      r_open_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_open_cnt <= w_open_nxt;
    end
  end

  always_comb begin
    checker_en  = (r_state == ARMED);
    checker_clr = (r_state != ARMED);
    unlocked    = (r_state == OPEN);
    locked      = (r_state == LOCKED);
    tries_left  = locked ? 2'd0 : MAX_T - r_fail_cnt;
  end

  assign w_seg_val = locked ? r_lock_cnt
                            : {2'b00, tries_left};

  seg7_digit u_seg (
    .i_val (w_seg_val),
    .o_seg (w_seg)
  );

  always_comb begin
    HEX4 = w_seg;
    if (r_state == OPEN)
      HEX4 = SEG_O;
    else if (r_state == WAIT_CLR)
      HEX4 = SEG_GUION;
  end

endmodule

// File: tb/tb_password_lockout_ctrl.sv
// Self-checking bench for password_lockout_ctrl against
// a behavioural model of the lockout rules.
module tb_password_lockout_ctrl;

  localparam int MAXT = 3;
  localparam int LT   = 9;
  localparam int OT   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       done_pulse = 1'b0;
  logic       error_pulse = 1'b0;
  logic       sw_any = 1'b0;
  logic       checker_en;
  logic       checker_clr;
  logic       unlocked;
  logic       locked;
  logic [1:0] tries_left;
  logic [6:0] HEX4;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode flags plus remaining counts
  int m_fails = 0;
  int m_lrem  = 0;
  int m_orem  = 0;
  bit m_lock  = 0;
  bit m_open  = 0;
  bit m_wait  = 0;

  logic [6:0] digit_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };
  localparam logic [6:0] G_O     = 7'b1000000;
  localparam logic [6:0] G_GUION = 7'b0111111;

  password_lockout_ctrl #(
    .MAX_TRIES  (MAXT),
    .LOCK_TICKS (LT),
    .OPEN_TICKS (OT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .done_pulse  (done_pulse),
    .error_pulse (error_pulse),
    .sw_any      (sw_any),
    .checker_en  (checker_en),
    .checker_clr (checker_clr),
    .unlocked    (unlocked),
    .locked      (locked),
    .tries_left  (tries_left),
    .HEX4        (HEX4)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_fails = 0; m_lrem = 0; m_orem = 0;
    m_lock = 0; m_open = 0; m_wait = 0;
  endfunction

  function automatic void model_step(bit t, bit d, bit e, bit s);
    if (m_wait) begin
      if (!s) m_wait = 0;
    end else if (m_lock) begin
      if (t && m_lrem > 0) begin
        m_lrem--;
        if (m_lrem == 0) begin m_lock = 0; m_wait = 1; end
      end
    end else if (m_open) begin
      if (t && m_orem > 0) begin
        m_orem--;
        if (m_orem == 0) begin m_open = 0; m_wait = 1; end
      end
    end else if (e) begin
      m_fails++;
      if (m_fails == MAXT) begin
        m_fails = 0; m_lock = 1; m_lrem = LT;
      end
    end else if (d) begin
      m_fails = 0; m_open = 1; m_orem = OT;
    end
  endfunction

  function automatic bit m_armed();
    return !m_lock && !m_open && !m_wait;
  endfunction

  function automatic logic [6:0] exp_hex();
    if (m_open) return G_O;
    if (m_wait) return G_GUION;
    if (m_lock) return digit_tab[m_lrem];
    return digit_tab[MAXT - m_fails];
  endfunction

  function automatic logic [1:0] exp_tries();
    if (m_lock) return 2'd0;
    return 2'(MAXT - m_fails);
  endfunction

  task automatic cyc(input bit t, input bit d,
                     input bit e, input bit s);
    tick = t; done_pulse = d; error_pulse = e; sw_any = s;
    @(posedge clk);
    model_step(t, d, e, s);
    #1;
    tick = 0; done_pulse = 0; error_pulse = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    sw_any = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({checker_en, checker_clr, unlocked, locked}
        !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got %b want 1000",
               {checker_en, checker_clr, unlocked, locked});
    end
    checks++;
    if (tries_left !== 2'(MAXT) || HEX4 !== digit_tab[MAXT]) begin
      errors++;
      $display("FAIL reset_tries got %0d/%b want %0d/%b",
               tries_left, HEX4, MAXT, digit_tab[MAXT]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_lockout();
    apply_reset();
    for (int i = 0; i < MAXT - 1; i++) begin
      checks++;
      if (tries_left !== 2'(MAXT - i)) begin
        errors++;
        $display("FAIL lockout_tries%0d got %0d want %0d",
                 i, tries_left, MAXT - i);
      end
      cyc(0, 0, 1, 0);
    end
    checks++;
    if (tries_left !== 2'd1) begin
      errors++;
      $display("FAIL lockout_last got %0d want 1", tries_left);
    end
    // final error with a coincident tick: load must survive
    cyc(1, 0, 1, 0);
    checks++;
    if (locked !== 1'b1 || checker_clr !== 1'b1 ||
        checker_en !== 1'b0 || tries_left !== 2'd0) begin
      errors++;
      $display("FAIL lockout_state got l%b c%b e%b t%0d want 1 1 0 0",
               locked, checker_clr, checker_en, tries_left);
    end
    checks++;
    if (HEX4 !== digit_tab[LT]) begin
      errors++;
      $display("FAIL lockout_hex got %b want %b",
               HEX4, digit_tab[LT]);
    end
  endtask

  task automatic test_lock_expire();
    for (int n = LT; n >= 1; n--) begin
      checks++;
      if (HEX4 !== digit_tab[n] || locked !== 1'b1) begin
        errors++;
        $display("FAIL expire_cnt%0d got %b/%b want %b/1",
                 n, HEX4, locked, digit_tab[n]);
      end
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
    end
    checks++;
    if (HEX4 !== G_GUION || locked !== 1'b0 ||
        checker_clr !== 1'b1) begin
      errors++;
      $display("FAIL expire_wait got %b/%b/%b want %b/0/1",
               HEX4, locked, checker_clr, G_GUION);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (checker_en !== 1'b1 || tries_left !== 2'(MAXT)) begin
      errors++;
      $display("FAIL expire_armed got %b/%0d want 1/%0d",
               checker_en, tries_left, MAXT);
    end
  endtask

  task automatic test_open();
    apply_reset();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    for (int n = OT; n >= 1; n--) begin
      checks++;
      if (unlocked !== 1'b1 || HEX4 !== G_O ||
          checker_clr !== 1'b1) begin
        errors++;
        $display("FAIL open_win%0d got u%b h%b c%b want 1 %b 1",
                 n, unlocked, HEX4, checker_clr, G_O);
      end
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 0);
    end
    checks++;
    if (unlocked !== 1'b0 || HEX4 !== G_GUION) begin
      errors++;
      $display("FAIL open_end got %b/%b want 0/%b",
               unlocked, HEX4, G_GUION);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (checker_en !== 1'b1 || tries_left !== 2'(MAXT)) begin
      errors++;
      $display("FAIL open_rearm got %b/%0d want 1/%0d",
               checker_en, tries_left, MAXT);
    end
  endtask

  task automatic test_both_pulses();
    apply_reset();
    cyc(0, 1, 1, 0);
    checks++;
    if (unlocked !== 1'b0 || tries_left !== 2'(MAXT - 1) ||
        checker_en !== 1'b1) begin
      errors++;
      $display("FAIL both_pulses got u%b t%0d e%b want 0 %0d 1",
               unlocked, tries_left, checker_en, MAXT - 1);
    end
  endtask

  task automatic test_wait_clr();
    apply_reset();
    for (int i = 0; i < MAXT; i++) cyc(0, 0, 1, 1);
    for (int i = 0; i < LT; i++) cyc(1, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (HEX4 !== G_GUION || checker_en !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold%0d got %b/%b want %b/0",
                 i, HEX4, checker_en, G_GUION);
      end
      cyc(1, i[0], 1, 1);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (checker_en !== 1'b1 || tries_left !== 2'(MAXT)) begin
      errors++;
      $display("FAIL wait_release got %b/%0d want 1/%0d",
               checker_en, tries_left, MAXT);
    end
  endtask

  task automatic test_reset_midlock();
    apply_reset();
    for (int i = 0; i < MAXT; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < LT - 4; i++) cyc(1, 0, 0, 0);
    checks++;
    if (HEX4 !== digit_tab[4] || locked !== 1'b1) begin
      errors++;
      $display("FAIL midlock_pre got %b/%b want %b/1",
               HEX4, locked, digit_tab[4]);
    end
    #1 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (locked !== 1'b0 || tries_left !== 2'(MAXT) ||
        checker_en !== 1'b1 || HEX4 !== digit_tab[MAXT]) begin
      errors++;
      $display("FAIL midlock_rst got l%b t%0d e%b h%b want 0 %0d 1",
               locked, tries_left, checker_en, HEX4, MAXT);
    end
    rst = 1'b1;
    for (int i = 0; i < MAXT; i++) cyc(1, 0, 1, 0);
    checks++;
    if (HEX4 !== digit_tab[LT] || locked !== 1'b1) begin
      errors++;
      $display("FAIL midlock_relock got %b/%b want %b/1",
               HEX4, locked, digit_tab[LT]);
    end
  endtask

  task automatic test_random();
    bit t, d, e, s;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      t = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 4) == 0);
      s = ($urandom_range(0, 3) == 0);
      cyc(t, d, e, s);
      checks++;
      if (HEX4 !== exp_hex()) begin
        errors++;
        $display("FAIL rand_hex@%0d got %b want %b",
                 i, HEX4, exp_hex());
      end
      checks++;
      if ({checker_en, checker_clr, unlocked, locked} !==
          {m_armed(), !m_armed(), m_open, m_lock}) begin
        errors++;
        $display("FAIL rand_flags@%0d got %b want %b", i,
                 {checker_en, checker_clr, unlocked, locked},
                 {m_armed(), !m_armed(), m_open, m_lock});
      end
      if (m_armed() || m_lock) begin
        checks++;
        if (tries_left !== exp_tries()) begin
          errors++;
          $display("FAIL rand_tries@%0d got %0d want %0d",
                   i, tries_left, exp_tries());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lockout();
    test_lock_expire();
    test_open();
    test_both_pulses();
    test_wait_clr();
    test_reset_midlock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/password_lockout_ctrl.md
PASSWORD_LOCKOUT_CTRL -- requirements
Module: password_lockout_ctrl

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 3: consecutive failed attempts that trigger lockout (range 1..3).
REQ-002 SHALL have parameter LOCK_TICKS, default 9: lockout duration in tick pulses (range 1..9).
REQ-003 SHALL have parameter OPEN_TICKS, default 5: unlocked duration in tick pulses (range 1..9).
REQ-004 clk  input  1  system clock; single clock domain for all logic.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  one-clk-wide pulse from the clock divider; the time base for all timers.
REQ-007 done_pulse  input  1  one-clk pulse from the password checker: correct code entered.
REQ-008 error_pulse  input  1  one-clk pulse from the password checker: wrong code entered.
REQ-009 sw_any  input  1  high while any switch is up (OR of SW[9:0]).
REQ-010 checker_en  output  1  high: the checker may accept entries.
REQ-011 checker_clr  output  1  high: the checker is forced to IDLE.
REQ-012 unlocked  output  1  high while the access window is open.
REQ-013 locked  output  1  high during lockout.
REQ-014 tries_left  output  2  remaining attempts before lockout.
REQ-015 HEX4  output  7  active-low 7-segment status digit.

Function
REQ-016 The FSM SHALL have states ARMED, OPEN, LOCKED and WAIT_CLR, and SHALL encode the next state combinationally and register it on posedge clk.
REQ-017 ARMED: checker_en=1, checker_clr=0, tries_left=MAX_TRIES-fail_cnt.
REQ-018 ARMED + error_pulse: fail_cnt+1; if the new value equals MAX_TRIES -> LOCKED next cycle, fail_cnt=0, lock_cnt=LOCK_TICKS.
REQ-019 ARMED + done_pulse (error_pulse low): -> OPEN, fail_cnt=0, open_cnt=OPEN_TICKS.
REQ-020 When done_pulse and error_pulse occur in the same cycle, error_pulse SHALL win.
REQ-021 OPEN: unlocked=1, checker_en=0, checker_clr=1; open_cnt decrements on each tick; tick at open_cnt=1 -> WAIT_CLR.
REQ-022 LOCKED: locked=1, checker_en=0, checker_clr=1, tries_left=0; lock_cnt decrements on each tick; tick at lock_cnt=1 -> WAIT_CLR.
REQ-023 WAIT_CLR: checker_en=0, checker_clr=1; -> ARMED in the first cycle with sw_any=0; remains in WAIT_CLR while sw_any=1.
REQ-024 done_pulse and error_pulse SHALL be ignored in every state except ARMED.
REQ-025 A state transition and a timer load in the same cycle SHALL take effect together on the same clk edge.
REQ-026 A tick arriving in the cycle of entry into OPEN or LOCKED SHALL NOT decrement the freshly loaded counter.
REQ-027 Counters SHALL be 4-bit, SHALL never wrap below 0, and SHALL never exceed their load value.
REQ-028 HEX4 SHALL show:
  - ARMED: digit tries_left
  - LOCKED: digit lock_cnt
  - OPEN: 'O' (7'b1000000)
  - WAIT_CLR: '-' (7'b0111111)
REQ-029 All outputs SHALL be functions of registered state and counters only (Moore); no input-to-output combinational path.

Reset
REQ-030 On rst=0, asynchronously: state=ARMED, fail_cnt=0, lock_cnt=0, open_cnt=0.
REQ-031 During reset, outputs SHALL read checker_en=1, checker_clr=0, unlocked=0, locked=0, tries_left=MAX_TRIES, HEX4=digit MAX_TRIES.
REQ-032 Reset asserted mid-lockout or mid-open SHALL abort the timer immediately with no residual state.

Structure
REQ-033 State encodings and the 7-segment glyph constants (O, GUION, BLANK, digits 0-9) SHALL live in a shared package/include, pw_pkg.
REQ-034 One sub-module, seg7_digit (4-bit value -> active-low 7-segment code), SHALL be instantiated for HEX4.
REQ-035 The block SHALL instantiate no clock divider; tick is supplied by the existing clkdiv.

Verification
REQ-036 Reset, then 3 error_pulses with MAX_TRIES=3 -> tries_left 3,2,1, then locked=1, HEX4 shows 9, checker_clr=1.
REQ-037 In LOCKED, 9 ticks with sw_any=0 -> lock_cnt counts 9..1, then WAIT_CLR, then ARMED one cycle later with tries_left=3.
REQ-038 2 errors then done_pulse -> OPEN, unlocked=1 for 5 ticks; back in ARMED, tries_left=3.
REQ-039 done_pulse and error_pulse in the same cycle in ARMED -> counted as an error, no OPEN.
REQ-040 sw_any held at 1 after lockout expires -> remains in WAIT_CLR (HEX4='-') until sw_any=0; error_pulse during WAIT_CLR is ignored.
REQ-041 rst pulsed low mid-LOCKED (lock_cnt=4) -> ARMED immediately, locked=0, tries_left=3.
